dcache_4kb: RTL and testbench

- Single-cycle, always-hit 4 KB data memory for the load/store path.
- Sits behind the load/store queue and takes one request per cycle: a read or a write, tagged with a load/store ID.
- Returns a registered response one cycle later with read data, the echoed ID and a ready pulse.
- There is no miss path, no backing store and no stall output.

---
 rtl/lsq_mem_pkg.sv | 15 +
 rtl/dcache_data_array.sv | 43 ++++
 rtl/dcache_4kb.sv | 83 ++++++++
 tb/tb_dcache_4kb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/lsq_mem_pkg.sv
// Shared load/store memory parameters, common to the load/store queue and the data cache.
package lsq_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;

  // Word index field inside the byte address
  localparam int unsigned IDX_LO = 2;
  localparam int unsigned IDX_HI = 11;
  localparam int unsigned IDX_W  = IDX_HI - IDX_LO + 1;

  localparam int unsigned DEPTH  = 1024;

endpackage : lsq_mem_pkg

// File: rtl/dcache_data_array.sv
// Single-port synchronous data RAM, DEPTH x DATA_W, with a registered read port.
module dcache_data_array
  import lsq_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Read register loads only on a read so the last value is held otherwise
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[idx];
    end
  end

  // Read data register; reset clears the output but never the array
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule : dcache_data_array

// File: rtl/dcache_4kb.sv
// Always-hit 4 KB data cache: one request per cycle, registered response one cycle later.
module dcache_4kb
  import lsq_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memR,
  input  logic              memW,
  input  logic [ID_W-1:0]   ldstID,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Rdata,
  output logic [ID_W-1:0]   ldstID_out,
  output logic              ready_out
);

  logic              wr_req, rd_req, any_req;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] arr_rdata;

  logic              ready_d, ready_q;
  logic [ID_W-1:0]   id_d, id_q;
  logic              sel_wr_d, sel_wr_q;
  logic [DATA_W-1:0] wack_d, wack_q;

  // Byte-offset and above-4KB address bits do not select a word
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:IDX_HI+1], addr[IDX_LO-1:0]};

  // Request decode: write wins over a simultaneous read; nothing is accepted in reset
  always_comb begin
    wr_req  = rst & memW;
    rd_req  = rst & memR & ~memW;
    any_req = wr_req | rd_req;
    idx     = addr[IDX_HI:IDX_LO];
  end

  dcache_data_array u_array (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_req),
    .re    (rd_req),
    .idx   (idx),
    .wdata (Wdata),
    .rdata (arr_rdata)
  );

  // Response next-state: pulse ready per request, hold tag and data source when idle
  always_comb begin
    ready_d  = any_req;
    id_d     = id_q;
    sel_wr_d = sel_wr_q;
    wack_d   = wack_q;
    if (any_req) begin
      id_d     = ldstID;
      sel_wr_d = wr_req;
    end
    if (wr_req) begin
      wack_d = Wdata;
    end
  end

  // Response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      id_q     <= '0;
      sel_wr_q <= 1'b0;
      wack_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      id_q     <= id_d;
      sel_wr_q <= sel_wr_d;
      wack_q   <= wack_d;
    end
  end

  // Data out selects between two registered sources: write-ack echo or array read
  assign Rdata      = sel_wr_q ? wack_q : arr_rdata;
  assign ldstID_out = id_q;
  assign ready_out  = ready_q;

endmodule : dcache_4kb

// File: tb/tb_dcache_4kb.sv
// Self-checking bench for dcache_4kb: directed scenarios plus random traffic against a word-array model.
module tb_dcache_4kb;

  logic        clk = 1'b0;
  logic        rst;
  logic        memR, memW;
  logic [3:0]  ldstID;
  logic [31:0] addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic [3:0]  ldstID_out;
  logic        ready_out;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Reference model: 4 KB as 1024 words, with a written flag per word
  logic [31:0] ref_mem [1024];
  bit          ref_known [1024];
  logic [31:0] exp_rdata;
  bit          exp_rdata_known;
  logic [3:0]  exp_id;
  logic        exp_ready;

  dcache_4kb dut (
    .clk        (clk),
    .rst        (rst),
    .memR       (memR),
    .memW       (memW),
    .ldstID     (ldstID),
    .addr       (addr),
    .Wdata      (Wdata),
    .Rdata      (Rdata),
    .ldstID_out (ldstID_out),
    .ready_out  (ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Drive one request, advance one edge, update the model and compare the response
  task automatic step(input logic r, input logic w, input logic [3:0] id,
                      input logic [31:0] a, input logic [31:0] d, input logic rs);
    int unsigned word;
    rst = rs; memR = r; memW = w; ldstID = id; addr = a; Wdata = d;
    @(posedge clk);
    word = (a % 4096) / 4;
    if (!rs) begin
      exp_ready = 1'b0; exp_id = '0; exp_rdata = '0; exp_rdata_known = 1'b1;
    end else if (w) begin
      ref_mem[word] = d; ref_known[word] = 1'b1;
      exp_ready = 1'b1; exp_id = id; exp_rdata = d; exp_rdata_known = 1'b1;
    end else if (r) begin
      exp_ready = 1'b1; exp_id = id;
      exp_rdata = ref_mem[word]; exp_rdata_known = ref_known[word];
    end else begin
      exp_ready = 1'b0;
    end
    #1;
    check("ready_out", 32'(ready_out), 32'(exp_ready));
    check("ldstID_out", 32'(ldstID_out), 32'(exp_id));
    if (exp_rdata_known) check("Rdata", Rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b0; memR = 1'b0; memW = 1'b0; ldstID = '0; addr = '0; Wdata = '0;
    exp_rdata = '0; exp_rdata_known = 1'b1; exp_id = '0; exp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ref_known[i] = 1'b0;
      ref_mem[i]   = '0;
    end

    // 1: requests during reset are dropped; first read after release responds
    step(1'b1, 1'b1, 4'd5, 32'd40, 32'h1234, 1'b0);
    step(1'b1, 1'b1, 4'd6, 32'd40, 32'h5678, 1'b0);
    step(1'b1, 1'b0, 4'd9, 32'd40, 32'h0, 1'b1);

    // 2: write/write/read/read back-to-back
    step(1'b0, 1'b1, 4'd1, 32'd40, 32'd9000, 1'b1);
    step(1'b0, 1'b1, 4'd2, 32'd44, 32'd9001, 1'b1);
    step(1'b1, 1'b0, 4'd3, 32'd40, 32'h0, 1'b1);
    step(1'b1, 1'b0, 4'd4, 32'd44, 32'h0, 1'b1);

    // 3: aliasing modulo 4 KB and ignored byte offset
    step(1'b0, 1'b1, 4'd8, 32'h0000_1002, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 1'b0, 4'd9, 32'h0000_0000, 32'h0, 1'b1);

    // 4: simultaneous read+write behaves as a write
    step(1'b1, 1'b1, 4'd7, 32'd8, 32'd5, 1'b1);
    step(1'b1, 1'b0, 4'd10, 32'd8, 32'h0, 1'b1);

    // 5: idle gap after a read of 9000 holds data and tag
    step(1'b1, 1'b0, 4'd11, 32'd40, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    check("idle_hold_rdata", Rdata, 32'd9000);
    check("idle_hold_id", 32'(ldstID_out), 32'd11);

    // 6: write under reset is lost; prior value remains
    step(1'b0, 1'b1, 4'd12, 32'd44, 32'd1, 1'b0);
    step(1'b1, 1'b0, 4'd13, 32'd44, 32'h0, 1'b1);
    check("reset_write_dropped", Rdata, 32'd9001);

    // Random traffic over a small word window with random high address bits
    for (int n = 0; n < 600; n++) begin
      logic        rr, ww, rs;
      logic [31:0] a;
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 2) == 0);
      rs = 1'($urandom_range(0, 39) != 0);
      a  = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 4'h0,
            6'($urandom_range(0, 15)), 2'($urandom)};
      step(rr, ww, 4'($urandom), a, $urandom, rs);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_dcache_4kb
